// File: rtl/lib_rr_output_arbiter.sv
// lib_rr_output_arbiter: per-output round-robin arbiter with packet locking.
// Zero-latency one-hot grant; a non-tail winner keeps the output until its tail is granted.
module lib_rr_output_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce,
    input  logic [0:N-1] i_request,
    input  logic         i_hold,
    input  logic         i_en,
    output logic [0:N-1] o_grant,
    output logic         o_grant_val,
    output logic         o_locked
);
    localparam int W = $clog2(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d, win;
    logic         lock_val_q, lock_val_d, found;
    int           idx;

    always_comb begin
        found       = 1'b0;
        win         = ptr_q;
        idx         = 0;
        // A held lock owns the output: no other input may win, even if the owner is idle.
        if (lock_val_q) begin
            found = i_request[lock_idx_q];
            win   = lock_idx_q;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (!found && i_request[idx]) begin
                    found = 1'b1;
                    win   = idx[W-1:0];
                end
            end
        end
        o_grant_val = reset_n && ce && i_en && found;
        o_grant     = '0;
        if (o_grant_val) o_grant[win] = 1'b1;
        ptr_d      = ptr_q;
        lock_val_d = lock_val_q;
        lock_idx_d = lock_idx_q;
        if (o_grant_val) begin
            ptr_d      = (win == LAST) ? '0 : win + W'(1);
            lock_val_d = i_hold;
            lock_idx_d = i_hold ? win : lock_idx_q;
        end else if (ce && i_en && lock_val_q && !i_request[lock_idx_q]) begin
            lock_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            lock_val_q <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_val_q <= lock_val_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign o_locked = lock_val_q;

    always @(posedge clk) begin
        if (reset_n) begin
            assert ($onehot0(o_grant));
            assert ((o_grant & ~i_request) == '0);
            assert (i_en || o_grant == '0);
        end
    end
endmodule

// File: tb/tb_lib_rr_output_arbiter.sv
// tb_lib_rr_output_arbiter: directed vectors with hand-computed grants for N=4.
module tb_lib_rr_output_arbiter;
    logic       clk = 1'b0;
    logic       reset_n, ce, i_hold, i_en;
    logic [0:3] i_request;
    logic [0:3] o_grant;
    logic       o_grant_val, o_locked;
    int         n_tot = 0, n_bad = 0;

    lib_rr_output_arbiter #(.N(4)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .i_request(i_request),
        .i_hold(i_hold), .i_en(i_en), .o_grant(o_grant),
        .o_grant_val(o_grant_val), .o_locked(o_locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs before the next rising edge.
    task automatic cyc(input string tag, input logic rst, input logic c, input logic [0:3] req,
                       input logic hold, input logic en, input logic [0:3] eg, input logic el,
                       input logic chk_l);
        @(negedge clk);
        reset_n   = rst;
        ce        = c;
        i_request = req;
        i_hold    = hold;
        i_en      = en;
        #1;
        chk({tag, ".grant"}, 32'(o_grant), 32'(eg));
        chk({tag, ".val"}, 32'(o_grant_val), 32'(|eg));
        if (chk_l) chk({tag, ".locked"}, 32'(o_locked), 32'(el));
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b1; i_request = '0; i_hold = 1'b0; i_en = 1'b1;
        cyc("rst0", 0, 1, 4'b1111, 0, 1, 4'b0000, 0, 0);
        cyc("rst1", 0, 1, 4'b1111, 0, 1, 4'b0000, 0, 1);
        cyc("rr0", 1, 1, 4'b1111, 0, 1, 4'b1000, 0, 1);
        cyc("rr1", 1, 1, 4'b1111, 0, 1, 4'b0100, 0, 1);
        cyc("rr2", 1, 1, 4'b1111, 0, 1, 4'b0010, 0, 1);
        cyc("rr3", 1, 1, 4'b1111, 0, 1, 4'b0001, 0, 1);
        cyc("rr4", 1, 1, 4'b1111, 0, 1, 4'b1000, 0, 1);
        cyc("rr5", 1, 1, 4'b1111, 0, 1, 4'b0100, 0, 1);
        cyc("rr6", 1, 1, 4'b1111, 0, 1, 4'b0010, 0, 1);
        cyc("rr7", 1, 1, 4'b1111, 0, 1, 4'b0001, 0, 1);
        cyc("wrap_set", 1, 1, 4'b0010, 0, 1, 4'b0010, 0, 1);
        cyc("wrap0", 1, 1, 4'b1010, 0, 1, 4'b1000, 0, 1);
        cyc("wrap1", 1, 1, 4'b1010, 0, 1, 4'b0010, 0, 1);
        cyc("lk_set", 1, 1, 4'b1000, 0, 1, 4'b1000, 0, 1);
        cyc("lk1", 1, 1, 4'b1111, 1, 1, 4'b0100, 0, 1);
        cyc("lk2", 1, 1, 4'b1111, 1, 1, 4'b0100, 1, 1);
        cyc("lk3", 1, 1, 4'b1111, 1, 1, 4'b0100, 1, 1);
        cyc("lk4", 1, 1, 4'b1111, 0, 1, 4'b0100, 1, 1);
        cyc("lk5", 1, 1, 4'b1111, 0, 1, 4'b0010, 0, 1);
        cyc("bp_lock", 1, 1, 4'b0010, 1, 1, 4'b0010, 0, 1);
        cyc("bp0", 1, 1, 4'b1111, 0, 0, 4'b0000, 1, 1);
        cyc("bp1", 1, 1, 4'b1111, 0, 0, 4'b0000, 1, 1);
        cyc("bp2", 1, 1, 4'b1111, 0, 0, 4'b0000, 1, 1);
        cyc("bp_resume", 1, 1, 4'b1111, 0, 1, 4'b0010, 1, 1);
        cyc("bp_ptr", 1, 1, 4'b1111, 0, 1, 4'b0001, 0, 1);
        cyc("st_lock", 1, 1, 4'b1000, 1, 1, 4'b1000, 0, 1);
        cyc("st_break", 1, 1, 4'b0110, 0, 1, 4'b0000, 1, 1);
        cyc("st_next", 1, 1, 4'b0110, 0, 1, 4'b0100, 0, 1);
        cyc("ce_lock", 1, 1, 4'b1000, 1, 1, 4'b1000, 0, 1);
        cyc("ce_off0", 1, 0, 4'b0110, 0, 1, 4'b0000, 1, 1);
        cyc("ce_off1", 1, 0, 4'b0110, 0, 1, 4'b0000, 1, 1);
        cyc("ce_break", 1, 1, 4'b0110, 0, 1, 4'b0000, 1, 1);
        cyc("ce_next", 1, 1, 4'b0110, 0, 1, 4'b0100, 0, 1);
        cyc("idle", 1, 1, 4'b0000, 0, 1, 4'b0000, 0, 1);
        cyc("after_idle", 1, 1, 4'b1111, 0, 1, 4'b0010, 0, 1);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/lib_rr_output_arbiter.md
Name: lib_rr_output_arbiter

Overview:
- Per-output-port round-robin arbiter in the switch stage, directly downstream of the per-input virtual output queues.
- Bit j of i_request comes from input j's VOQ valid for this output port.
- The one-hot o_grant is fanned back to each VOQ's per-output enable and also drives the crossbar select for this output.
- Supports packet locking, so multi-flit packets from one input are not interleaved with flits from other inputs.

Parameters:
- N, 4, number of input ports competing for this output (N >= 2). Bit 0 is the leftmost, MSB-first, [0:N-1].

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- reset_n, input, 1, synchronous active-low reset.
- ce, input, 1, clock enable; state advances only when ce=1.
- i_request, input, [0:N-1], request vector; bit j=1 means input j's VOQ holds a flit for this output.
- i_hold, input, 1, driven by the current winner's head flit; 1 means the flit is not a tail, so the grant is locked for the next flit.
- i_en, input, 1, downstream ready/credit for this output; 0 means no grant is issued.
- o_grant, output, [0:N-1], one-hot grant (or all zero); returned to the VOQ enables and the crossbar select.
- o_grant_val, output, 1, OR of o_grant.
- o_locked, output, 1, lock register currently set.

Behaviour:
- State registers:
  - Priority pointer ptr: ceil(log2 N) bits, range 0..N-1.
  - lock_val: 1 bit.
  - lock_idx: ceil(log2 N) bits.
- Reset: on a clk edge with reset_n=0, set ptr=0, lock_val=0, lock_idx=0. Reset takes priority over ce.
- Output gating: o_grant=0 and o_grant_val=0 whenever any of these hold: reset_n=0, ce=0, i_en=0, or i_request=0.
- Grant selection is combinational and in the same cycle, so zero-latency from request to grant:
  - If lock_val=1 and i_request[lock_idx]=1, grant lock_idx, ignoring ptr and all other requests.
  - Otherwise, scan indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1 and grant the first with i_request=1.
  - o_grant is a single bit at the winning index w.
- Updates on a clk edge with ce=1, reset_n=1 and o_grant_val=1:
  - ptr <= (w+1) mod N. This wraps, so w=N-1 gives ptr=0.
  - If i_hold=1: lock_val <= 1, lock_idx <= w.
  - If i_hold=0: lock_val <= 0 (tail flit granted; lock released).
- Updates on a clk edge with ce=1, reset_n=1 and o_grant_val=0:
  - ptr holds.
  - If lock_val=1 and i_request[lock_idx]=0 and i_en=1, clear lock_val. This breaks a stale lock from a starved or flushed VOQ.
  - If i_en=0, the lock is held regardless.
- ce=0: all registers hold and outputs are 0. No dequeue can happen without a matching state update.
- Simultaneous events:
  - While a lock is held, new requests from other inputs are ignored until the tail is granted.
  - If a locked requester drops its request while i_en=1, the lock breaks that cycle and no grant is issued that cycle. Normal round-robin resumes the next cycle.
- Fairness: with all N requesting continuously and i_hold=0, each input is granted exactly once in every N consecutive granted cycles.
- o_locked = lock_val. It is registered, so it reads 0 immediately after reset.
- Assertions to include:
  - o_grant is one-hot or zero.
  - o_grant is a subset of i_request.
  - o_grant=0 when i_en=0.

Test Plan (N=4):
- Reset: hold reset_n=0 for 2 cycles with i_request=1111, i_en=1 -> o_grant=0000, o_locked=0. After release, first grant is 1000 (index 0).
- Round-robin rotation: i_request=1111, i_hold=0, i_en=1 for 8 cycles -> grants 1000, 0100, 0010, 0001, 1000, 0100, 0010, 0001.
- Wrap and skip: ptr=3 after granting index 2, then i_request=1010 -> grant 1000 (wraps past 3 to 0), next ptr=1. Next cycle grant 0010.
- Lock: i_request=1111, grant index 1 with i_hold=1 for 3 cycles then i_hold=0 -> o_grant=0100 for 4 consecutive cycles, o_locked=1 during cycles 2-4. The 5th grant is 0010.
- Backpressure: while locked on index 2, i_en=0 for 3 cycles -> o_grant=0000, ptr and lock unchanged. With i_en=1 again, grant resumes at 0010.
- Stale lock and ce: lock on index 0, then i_request=0110 with i_en=1 -> cycle 1 grant 0000 and lock clears; cycle 2 grant 0100. Repeat with ce=0 -> o_grant=0000 and no state change.
